prio_enc_reg: RTL
=================

// Module: prio_enc_reg
// PURPOSE
//   Registered, parametrised N-input priority encoder with request latching, per-line masking and a
//   valid/ack handshake. Selectable fixed-priority (highest index wins) or round-robin arbitration.
//   Used as the request front-end ahead of interrupt and service logic. Supersedes the combinational
//   4:2 encoder for all new designs.
// PARAMETERS
//   N     8  number of request lines; legal range 2..64
//   EDGE  1  1 = latch request on a 0->1 transition; 0 = level (request re-arms while held high)
//   RR    0  0 = fixed priority (index N-1 highest); 1 = round-robin
//   IDX_W    localparam = $clog2(N); width of code
// PORTS
//   clk      in   1      clock; all state updates on the rising edge
//   rst_n    in   1      asynchronous reset, active-low
//   req      in   N      request lines, sampled on clk
//   mask     in   N      1 = line disabled from selection; its pending bit is kept, not cleared
//   ack      in   1      consumer accepts the presented code; acts only when valid=1
//   code     out  IDX_W  index of the presented request (registered)
//   valid    out  1      code is valid (registered)
//   pending  out  N      latched pending requests (register contents, mask not applied)
//   irq      out  1      |(pending & ~mask); combinational from the pending register and mask
// BEHAVIOUR
//   Reset (async assert, sync release): pending=0, req_q=0, valid=0, code=0, last=0, state IDLE.
//     A reset mid-presentation discards the code and all pending bits.
//     req_q=0 at reset: a line already high at reset release counts as a rising edge.
//   Capture every edge: req_q<=req. set = EDGE ? (req & ~req_q) : req.
//   pending <= (pending | set) & ~clr.
//     clr = onehot(code) when valid & ack, else 0.
//     If set and clr hit the same bit in the same cycle, set wins and the bit stays pending.
//   cand = pending & ~mask.
//   Selection when RR=0: the highest set index of cand.
//   Selection when RR=1: search order is last-1, last-2, ... wrapping through N-1 down to last.
//     With last=0 after reset, the order equals the fixed order.
//     On each accepted grant, last <= code.
//   FSM, 2 states:
//     IDLE:    if cand != 0, load code <= selected index, valid <= 1, go to PRESENT.
//              Otherwise hold valid=0.
//     PRESENT: code and valid are held stable while ack=0.
//              The code does not change on new higher-priority requests or on mask changes,
//              including masking the presented line itself.
//              On ack=1: clear that pending bit (subject to set-wins), update last if RR=1,
//              valid <= 0, go to IDLE.
//   Latency:
//     req sampled high at edge E0 -> pending bit set at E0 -> valid=1 and code set at E1.
//     ack sampled at edge Ek -> valid=0 at Ek; the next code is presented at Ek+1 at the earliest.
//   Throughput: at most 1 grant per 2 cycles. valid never stays high across an accepted ack.
//   ack while valid=0 is ignored with no side effects.
//   cand=0 forever: valid stays 0 and code holds its last value.
//   In the idle-low state code is don't-care for consumers; the bench must not check it.
//   Level mode (EDGE=0): a line held high re-enters pending the same cycle it is cleared.
//     Under fixed priority it is therefore re-granted continuously.
//     Starving lower lines here is expected; RR=1 exists for that case.
// TESTING
//   (N=4 unless stated)
//   1. Reset, then pulse req=4'b0100 for 1 cycle; ack held 0 ->
//      pending=0100 at E0; code=2, valid=1 at E1; held 10 cycles.
//      Then ack=1 for 1 cycle -> valid=0, pending=0000.
//   2. Fixed priority, simultaneous edges req=4'b1011, ack asserted on every valid ->
//      codes presented 3, 1, 0, one grant per 2 cycles; irq=0 after the third ack.
//   3. Mask: req=4'b1100 latched, mask=4'b1000 ->
//      code=2 presented; pending stays 1000, irq=0 after ack.
//      Clear mask -> code=3 presented next.
//   4. RR=1, EDGE=0, req held 4'b1111, ack on every valid ->
//      code sequence 3, 2, 1, 0, 3, 2, ... (no starvation).
//      Same stimulus with RR=0 -> code 3 repeated.
//   5. Set/clear collision: EDGE=1, presenting code=1, ack=1 in the same cycle as a fresh
//      0->1 edge on req[1] -> pending[1] stays 1 and code=1 is presented again 1 cycle later.
//   6. Assert rst_n=0 asynchronously mid-PRESENT with pending=1010 ->
//      valid=0 and pending=0 immediately, without waiting for a clk edge.
//      ack during reset has no effect.

Source files
------------

// File: rtl/prio_enc_reg.sv
// prio_enc_reg: registered N-input priority encoder with request latching, masking and valid/ack handshake.
// Fixed priority (highest index wins) or round-robin selection.
module prio_enc_reg #(
  parameter int N = 8,
  parameter int EDGE = 1,
  parameter int RR = 0,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic             ack,
  output logic [IDX_W-1:0] code,
  output logic             valid,
  output logic [N-1:0]     pending,
  output logic             irq
);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t state, state_nx;
  logic [N-1:0] req_q, set, clr, cand;
  logic [IDX_W-1:0] last, sel;
  logic take;
  assign set = (EDGE != 0) ? (req & ~req_q) : req;
  assign cand = pending & ~mask;
  assign irq = |cand;
  always_comb begin
    sel = '0;
    if (RR != 0) begin
      // walk from farthest to nearest so the line right below last wins
      for (int i = N; i >= 1; i--)
        if (cand[(int'(last) + N - i) % N]) sel = IDX_W'((int'(last) + N - i) % N);
    end else begin
      for (int i = 0; i < N; i++)
        if (cand[i]) sel = IDX_W'(i);
    end
  end
  always_comb state_nx = (state == IDLE) ? ((|cand) ? PRESENT : IDLE) : (ack ? IDLE : PRESENT);
  always_comb begin
    valid = state == PRESENT;
    take = valid & ack;
    clr = take ? (N'(1) << code) : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      req_q <= '0;
      pending <= '0;
      code <= '0;
      last <= '0;
    end else begin
      state <= state_nx;
      req_q <= req;
      pending <= (pending & ~clr) | set;
      if (state == IDLE && (|cand)) code <= sel;
      if (take && RR != 0) last <= code;
    end
  end
endmodule
